id_ex_ctrl_stage: RTL and testbench

ID_EX_CTRL_STAGE -- requirements
Module: id_ex_ctrl_stage

---
 rtl/riscv_pipe_pkg.sv | 52 +++++
 rtl/id_ex_ctrl_stage_hazard_detect.sv | 31 +++
 rtl/id_ex_ctrl_stage.sv | 176 +++++++++++++++++
 tb/tb_id_ex_ctrl_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg
// Shared types and constants for the ID/EX control stage: legal opcode
// constants, the RUN/BUBBLE hazard state enum, the packed EX control bundle
// and an opcode legality helper.
package riscv_pipe_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } pipe_state_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic       jal_or_jalr;
      logic       alu_src1;
      logic [1:0] alu_src2;
      logic [6:0] alu_op;
      logic [3:0] be;
      logic [2:0] concat_control;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } ex_ctrl_t;

   localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

   function automatic logic opcode_legal(input logic [6:0] op);
      logic legal;
      case (op)
         OP_LUI, OP_AUIPC, OP_RTYPE, OP_ITYPE, OP_LOAD,
         OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: legal = 1'b1;
         default:                              legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/id_ex_ctrl_stage_hazard_detect.sv
// hazard_detect
// Purely combinational load-use compare between the instruction in ID and
// the load currently held in EX.
// Ports:
//   i_id_valid, i_use_rs1, i_use_rs2, i_rs1, i_rs2 : ID instruction sources
//   i_ex_valid, i_ex_mem_read, i_ex_rd             : EX stage load info
//   o_load_use                                     : ID needs a value EX has not loaded yet
module hazard_detect
   import riscv_pipe_pkg::*;
(
   input  logic       i_id_valid,
   input  logic       i_use_rs1,
   input  logic       i_use_rs2,
   input  logic [4:0] i_rs1,
   input  logic [4:0] i_rs2,
   input  logic       i_ex_valid,
   input  logic       i_ex_mem_read,
   input  logic [4:0] i_ex_rd,
   output logic       o_load_use
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   // x0 is never a real dependency, so a load to rd=0 cannot stall.
   assign w_rs1_hit  = i_use_rs1 & (i_rs1 == i_ex_rd);
   assign w_rs2_hit  = i_use_rs2 & (i_rs2 == i_ex_rd);
   assign o_load_use = i_id_valid & i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0)
                     & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage
// ID/EX pipeline register for decoder controls with load-use stall, flush
// bubble insertion, illegal-opcode detection and optional hazard counters.
//
// state  | meaning
// RUN    | normal flow; a load-use hazard stalls IF/ID and inserts a bubble
// BUBBLE | bubble just inserted; held ID instruction passes without re-stall
//
// Ports:
//   CLK, RSTn                 : clock, async active-low reset
//   id_*                      : decoded controls / register ids from ID
//   use_rs1_id, use_rs2_id    : ID instruction reads rs1 / rs2
//   flush_ex                  : EX resolved a taken branch/jump
//   ex_*                      : registered EX copies of the controls
//   stall_if_id               : hold PC and IF/ID this cycle
//   illegal_flag              : sticky illegal opcode seen in ID
//   bubble_cnt, flush_cnt     : event counters
// Build option: HAZARD_CNT_EN implements the counters; otherwise both read 0.
module id_ex_ctrl_stage
   import riscv_pipe_pkg::*;
(
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        id_valid,
   input  logic [6:0]  id_opcode,
   input  logic        id_RegWrite,
   input  logic        id_MemRead,
   input  logic        id_MemWrite,
   input  logic        id_MemtoReg,
   input  logic        id_Branch,
   input  logic        id_Jump,
   input  logic        id_JALorJALR,
   input  logic        id_ALUSrc1,
   input  logic [1:0]  id_ALUSrc2,
   input  logic [6:0]  id_ALUOp,
   input  logic [3:0]  id_BE,
   input  logic [2:0]  id_Concat_control,
   input  logic        use_rs1_id,
   input  logic        use_rs2_id,
   input  logic [4:0]  rs1_id,
   input  logic [4:0]  rs2_id,
   input  logic [4:0]  rd_id,
   input  logic        flush_ex,
   output logic        ex_RegWrite,
   output logic        ex_MemRead,
   output logic        ex_MemWrite,
   output logic        ex_MemtoReg,
   output logic        ex_Branch,
   output logic        ex_Jump,
   output logic        ex_JALorJALR,
   output logic        ex_ALUSrc1,
   output logic [1:0]  ex_ALUSrc2,
   output logic [6:0]  ex_ALUOp,
   output logic [3:0]  ex_BE,
   output logic [2:0]  ex_Concat_control,
   output logic [4:0]  ex_rd,
   output logic [4:0]  ex_rs1,
   output logic [4:0]  ex_rs2,
   output logic        ex_valid,
   output logic        stall_if_id,
   output logic        illegal_flag,
   output logic [31:0] bubble_cnt,
   output logic [31:0] flush_cnt
);

   pipe_state_t r_state;
   pipe_state_t w_state_nxt;
   ex_ctrl_t    r_ex;
   ex_ctrl_t    w_ex_nxt;
   logic        r_ex_valid;
   logic        r_illegal;
   logic        w_load_use;
   logic        w_legal;
   logic        w_stall;
   logic        w_bubble;

   hazard_detect u_hazard_detect (
      .i_id_valid    (id_valid),
      .i_use_rs1     (use_rs1_id),
      .i_use_rs2     (use_rs2_id),
      .i_rs1         (rs1_id),
      .i_rs2         (rs2_id),
      .i_ex_valid    (r_ex_valid),
      .i_ex_mem_read (r_ex.mem_read),
      .i_ex_rd       (r_ex.rd),
      .o_load_use    (w_load_use)
   );

   always_comb begin
      w_legal     = opcode_legal(id_opcode);
      w_stall     = w_load_use & ~flush_ex & (r_state == ST_RUN);
      w_bubble    = w_stall | flush_ex | ~id_valid | ~w_legal;
      w_state_nxt = r_state;
      w_ex_nxt    = EX_CTRL_BUBBLE;

      if (!w_bubble) begin
         w_ex_nxt.reg_write      = id_RegWrite;
         w_ex_nxt.mem_read       = id_MemRead;
         w_ex_nxt.mem_write      = id_MemWrite;
         w_ex_nxt.mem_to_reg     = id_MemtoReg;
         w_ex_nxt.branch         = id_Branch;
         w_ex_nxt.jump           = id_Jump;
         w_ex_nxt.jal_or_jalr    = id_JALorJALR;
         w_ex_nxt.alu_src1       = id_ALUSrc1;
         w_ex_nxt.alu_src2       = id_ALUSrc2;
         w_ex_nxt.alu_op         = id_ALUOp;
         w_ex_nxt.be             = id_BE;
         w_ex_nxt.concat_control = id_Concat_control;
         w_ex_nxt.rd             = rd_id;
         w_ex_nxt.rs1            = rs1_id;
         w_ex_nxt.rs2            = rs2_id;
      end

      case (r_state)
         ST_RUN:    if (w_load_use && !flush_ex) w_state_nxt = ST_BUBBLE;
         ST_BUBBLE: w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state    <= ST_RUN;
         r_ex       <= EX_CTRL_BUBBLE;
         r_ex_valid <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ex       <= w_ex_nxt;
         r_ex_valid <= ~w_bubble;
         if (id_valid && !w_legal && !flush_ex) r_illegal <= 1'b1;
      end
   end

`ifdef HAZARD_CNT_EN
   logic [31:0] r_bubble_cnt;
   logic [31:0] r_flush_cnt;

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
      end else begin
         if (w_stall && (r_bubble_cnt != 32'hFFFF_FFFF)) r_bubble_cnt <= r_bubble_cnt + 32'd1;
         if (flush_ex && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign bubble_cnt = r_bubble_cnt;
   assign flush_cnt  = r_flush_cnt;
`else
   assign bubble_cnt = 32'd0;
   assign flush_cnt  = 32'd0;
`endif

   assign ex_RegWrite       = r_ex.reg_write;
   assign ex_MemRead        = r_ex.mem_read;
   assign ex_MemWrite       = r_ex.mem_write;
   assign ex_MemtoReg       = r_ex.mem_to_reg;
   assign ex_Branch         = r_ex.branch;
   assign ex_Jump           = r_ex.jump;
   assign ex_JALorJALR      = r_ex.jal_or_jalr;
   assign ex_ALUSrc1        = r_ex.alu_src1;
   assign ex_ALUSrc2        = r_ex.alu_src2;
   assign ex_ALUOp          = r_ex.alu_op;
   assign ex_BE             = r_ex.be;
   assign ex_Concat_control = r_ex.concat_control;
   assign ex_rd             = r_ex.rd;
   assign ex_rs1            = r_ex.rs1;
   assign ex_rs2            = r_ex.rs2;
   assign ex_valid          = r_ex_valid;
   assign stall_if_id       = w_stall;
   assign illegal_flag      = r_illegal;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
module tb_id_ex_ctrl_stage;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        id_valid;
   logic [6:0]  id_opcode;
   logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg;
   logic        id_Branch, id_Jump, id_JALorJALR, id_ALUSrc1;
   logic [1:0]  id_ALUSrc2;
   logic [6:0]  id_ALUOp;
   logic [3:0]  id_BE;
   logic [2:0]  id_Concat_control;
   logic        use_rs1_id, use_rs2_id;
   logic [4:0]  rs1_id, rs2_id, rd_id;
   logic        flush_ex;
   logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;
   logic        ex_Branch, ex_Jump, ex_JALorJALR, ex_ALUSrc1;
   logic [1:0]  ex_ALUSrc2;
   logic [6:0]  ex_ALUOp;
   logic [3:0]  ex_BE;
   logic [2:0]  ex_Concat_control;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;
   logic        ex_valid, stall_if_id, illegal_flag;
   logic [31:0] bubble_cnt, flush_cnt;

   id_ex_ctrl_stage dut (
      .CLK(CLK), .RSTn(RSTn), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
      .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch), .id_Jump(id_Jump),
      .id_JALorJALR(id_JALorJALR), .id_ALUSrc1(id_ALUSrc1), .id_ALUSrc2(id_ALUSrc2),
      .id_ALUOp(id_ALUOp), .id_BE(id_BE), .id_Concat_control(id_Concat_control),
      .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rs1_id(rs1_id),
      .rs2_id(rs2_id), .rd_id(rd_id), .flush_ex(flush_ex),
      .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
      .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch), .ex_Jump(ex_Jump),
      .ex_JALorJALR(ex_JALorJALR), .ex_ALUSrc1(ex_ALUSrc1), .ex_ALUSrc2(ex_ALUSrc2),
      .ex_ALUOp(ex_ALUOp), .ex_BE(ex_BE), .ex_Concat_control(ex_Concat_control),
      .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_valid(ex_valid),
      .stall_if_id(stall_if_id), .illegal_flag(illegal_flag),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       valid;
      logic [6:0] op;
      logic       rw, mr, mw, m2r, br, jp, jl, a1;
      logic [1:0] a2;
      logic [6:0] aluop;
      logic [3:0] be;
      logic [2:0] cc;
      logic       u1, u2;
      logic [4:0] rs1, rs2, rd;
      logic       flush;
   } id_t;

   typedef struct {
      logic [39:0] ex;
      logic        ill;
      logic [31:0] bc;
      logic [31:0] fc;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   // Reference state: what EX holds, in instruction terms
   logic        m_valid, m_mr, m_after_stall, m_ill;
   logic [4:0]  m_rd;
   int unsigned m_stalls, m_flushes;

   logic [6:0] legal_ops [9] = '{7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011,
                                 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};

   function automatic logic is_legal(input logic [6:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [39:0] act_vec();
      return {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch,
              ex_Jump, ex_JALorJALR, ex_ALUSrc1, ex_ALUSrc2, ex_ALUOp, ex_BE,
              ex_Concat_control, ex_rd, ex_rs1, ex_rs2};
   endfunction

   function automatic logic [39:0] instr_vec(input id_t s);
      return {1'b1, s.rw, s.mr, s.mw, s.m2r, s.br, s.jp, s.jl, s.a1, s.a2,
              s.aluop, s.be, s.cc, s.rd, s.rs1, s.rs2};
   endfunction

   function automatic logic [31:0] cnt_exp(input int unsigned n);
`ifdef HAZARD_CNT_EN
      return 32'(n);
`else
      return (n == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   function automatic id_t mk(input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic mr,
                              input logic flush);
      id_t s;
      s = '{valid:1'b1, op:op, rw:1'b1, mr:mr, mw:1'b0, m2r:mr, br:1'b0, jp:1'b0,
            jl:1'b0, a1:1'b0, a2:2'd0, aluop:7'h0, be:4'hF, cc:3'd0, u1:u1, u2:u2,
            rs1:rs1, rs2:rs2, rd:rd, flush:flush};
      return s;
   endfunction

   function automatic id_t rnd();
      id_t s;
      s.valid = ($urandom_range(0, 99) < 85);
      s.op    = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127))
                                            : legal_ops[$urandom_range(0, 8)];
      s.rw    = 1'($urandom_range(0, 1));
      s.mr    = 1'($urandom_range(0, 1));
      s.mw    = 1'($urandom_range(0, 1));
      s.m2r   = 1'($urandom_range(0, 1));
      s.br    = 1'($urandom_range(0, 1));
      s.jp    = 1'($urandom_range(0, 1));
      s.jl    = 1'($urandom_range(0, 1));
      s.a1    = 1'($urandom_range(0, 1));
      s.a2    = 2'($urandom_range(0, 3));
      s.aluop = 7'($urandom_range(0, 127));
      s.be    = 4'($urandom_range(0, 15));
      s.cc    = 3'($urandom_range(0, 7));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.rd    = 5'($urandom_range(0, 3));
      s.flush = ($urandom_range(0, 99) < 10);
      return s;
   endfunction

   task automatic apply(input id_t s);
      id_valid = s.valid; id_opcode = s.op;
      id_RegWrite = s.rw; id_MemRead = s.mr; id_MemWrite = s.mw; id_MemtoReg = s.m2r;
      id_Branch = s.br; id_Jump = s.jp; id_JALorJALR = s.jl; id_ALUSrc1 = s.a1;
      id_ALUSrc2 = s.a2; id_ALUOp = s.aluop; id_BE = s.be; id_Concat_control = s.cc;
      use_rs1_id = s.u1; use_rs2_id = s.u2; rs1_id = s.rs1; rs2_id = s.rs2;
      rd_id = s.rd; flush_ex = s.flush;
   endtask

   task automatic model_reset();
      m_valid = 0; m_mr = 0; m_rd = 0; m_after_stall = 0; m_ill = 0;
      m_stalls = 0; m_flushes = 0;
      q.delete();
   endtask

   // One cycle: drive ID at negedge, check stall, push the EX contents the
   // instruction stream should show after the next rising edge.
   // Returns the expected stall so callers can replay a held instruction.
   task automatic step(input id_t s, output logic stalled);
      logic dep, stall, enters;
      exp_t e;
      @(negedge CLK);
      apply(s);
      #1;
      dep = s.valid && m_valid && m_mr && (m_rd != 0) &&
            ((s.u1 && s.rs1 == m_rd) || (s.u2 && s.rs2 == m_rd));
      stall = dep && !s.flush && !m_after_stall;
      checks++;
      if (stall_if_id !== stall) begin
         failures++;
         $display("FAIL stall_if_id t=%0t got=%b exp=%b", $time, stall_if_id, stall);
      end
      enters = s.valid && is_legal(s.op) && !s.flush && !stall;
      if (s.valid && !is_legal(s.op) && !s.flush) m_ill = 1;
      if (stall) m_stalls++;
      if (s.flush) m_flushes++;
      e.ex  = enters ? instr_vec(s) : 40'd0;
      e.ill = m_ill;
      e.bc  = cnt_exp(m_stalls);
      e.fc  = cnt_exp(m_flushes);
      q.push_back(e);
      m_valid = enters; m_mr = enters && s.mr; m_rd = enters ? s.rd : 5'd0;
      m_after_stall = stall;
      stalled = stall;
   endtask

   // Issue an instruction and keep presenting it while the stage holds IF/ID.
   task automatic issue(input id_t s);
      logic st;
      int guard = 0;
      step(s, st);
      while (st && guard < 4) begin
         s.flush = 1'b0;
         step(s, st);
         guard++;
      end
   endtask

   task automatic check_reset_state(input string tag);
      checks++;
      if (act_vec() !== 40'd0) begin
         failures++; $display("FAIL %s ex_fields got=%h exp=0", tag, act_vec());
      end
      checks++;
      if (stall_if_id !== 1'b0) begin
         failures++; $display("FAIL %s stall got=%b exp=0", tag, stall_if_id);
      end
      checks++;
      if (illegal_flag !== 1'b0) begin
         failures++; $display("FAIL %s illegal_flag got=%b exp=0", tag, illegal_flag);
      end
      checks++;
      if (bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         failures++; $display("FAIL %s counters got=%0d/%0d exp=0/0", tag, bubble_cnt, flush_cnt);
      end
   endtask

   // Monitor: compare EX after each rising edge against the scoreboard
   always begin
      exp_t e;
      @(posedge CLK);
      #1;
      if (RSTn === 1'b1 && q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (act_vec() !== e.ex) begin
            failures++; $display("FAIL ex_fields t=%0t got=%h exp=%h", $time, act_vec(), e.ex);
         end
         checks++;
         if (illegal_flag !== e.ill) begin
            failures++; $display("FAIL illegal_flag t=%0t got=%b exp=%b", $time, illegal_flag, e.ill);
         end
         checks++;
         if (bubble_cnt !== e.bc) begin
            failures++; $display("FAIL bubble_cnt t=%0t got=%0d exp=%0d", $time, bubble_cnt, e.bc);
         end
         checks++;
         if (flush_cnt !== e.fc) begin
            failures++; $display("FAIL flush_cnt t=%0t got=%0d exp=%0d", $time, flush_cnt, e.fc);
         end
      end
   end

   initial begin
      id_t idle;
      idle = mk(7'b0110011, 0, 0, 0, 0, 0, 0, 0);
      idle.valid = 0;
      RSTn = 0;
      apply(idle);
      model_reset();
      repeat (2) @(posedge CLK);
      #2;
      check_reset_state("reset");
      @(negedge CLK);
      RSTn = 1;

      // R-type add rd=5
      issue(mk(7'b0110011, 5, 1, 2, 1, 1, 0, 0));
      // LW x3 then ADD using x3 -> one stall, then ADD enters
      issue(mk(7'b0000011, 3, 1, 0, 1, 0, 1, 0));
      issue(mk(7'b0110011, 6, 3, 4, 1, 1, 0, 0));
      // load to x0, and rs2 match with use_rs2_id=0: no stall
      issue(mk(7'b0000011, 0, 1, 0, 1, 0, 1, 0));
      issue(mk(7'b0110011, 7, 0, 0, 1, 1, 0, 0));
      issue(mk(7'b0000011, 4, 1, 0, 1, 0, 1, 0));
      issue(mk(7'b0110011, 8, 1, 4, 1, 0, 0, 0));
      // load-use coinciding with flush
      issue(mk(7'b0000011, 2, 1, 0, 1, 0, 1, 0));
      issue(mk(7'b0110011, 9, 2, 1, 1, 0, 0, 1));
      // illegal opcode
      issue(mk(7'b1111111, 10, 1, 1, 1, 1, 0, 0));
      issue(mk(7'b0010011, 11, 1, 0, 1, 0, 0, 0));

      for (int i = 0; i < 400; i++) issue(rnd());

      // Reset while in BUBBLE
      issue(mk(7'b0000011, 1, 2, 0, 1, 0, 1, 0));
      begin
         logic st;
         step(mk(7'b0110011, 12, 1, 0, 1, 0, 0, 0), st);
      end
      @(posedge CLK);
      #3;
      RSTn = 0;
      #1;
      check_reset_state("reset_mid_stall");
      model_reset();
      @(posedge CLK);
      #2;
      check_reset_state("reset_held");
      @(negedge CLK);
      RSTn = 1;
      issue(mk(7'b0110011, 12, 1, 0, 1, 0, 0, 0));
      for (int i = 0; i < 100; i++) issue(rnd());

      repeat (3) @(posedge CLK);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++; $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
